// File: rtl/key_event_mapper.sv
// Key press/release event detector with short/long hold classification,
// mode/page code mapping and a valid/ready output FIFO.
module key_event_mapper #(
  parameter int NUM_KEYS          = 12,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int FIFO_DEPTH        = 4,
  parameter int CNT_W             = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [2:0]          state,
  input  logic [NUM_KEYS-1:0] key_down,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_long,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HELD, EMIT} fsm_t;

  fsm_t                fsm, fsm_next;
  logic [NUM_KEYS-1:0] key_q;
  logic                primed;
  logic [NUM_KEYS-1:0] rise;
  logic [3:0]          kidx, first_idx;
  logic                any_rise;
  logic [1:0]          mode_s;
  logic [2:0]          state_s;
  logic [CNT_W-1:0]    cnt;
  logic                long_s, long_now, key_held;
  logic [7:0]          code;
  logic                push_q, push_long;
  logic [7:0]          push_code;
  logic [8:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, pop, push_ok;

  function automatic logic [7:0] map_code(input logic [1:0] m, input logic [2:0] pg,
                                          input logic [3:0] k, input logic lng);
    logic [7:0] c;
    c = '0;
    case (k)
      4'd10: c = 8'h1B;
      4'd11: c = lng ? 8'h1B : 8'h08;
      4'd12: c = 8'h0D;
      default: begin
        if (k <= 4'd9) begin
          case (m)
            2'd0: begin
              if (k == 4'd9) c = 8'h20;
              else if (k >= 4'd1) begin
                case (pg)
                  3'd0: c = 8'h30 + 8'(k);
                  3'd1: c = (k == 4'd1) ? 8'h39 : (k == 4'd2) ? 8'h30 : 8'h3E + 8'(k);
                  3'd2: c = 8'h46 + 8'(k);
                  3'd3: c = 8'h4E + 8'(k);
                  3'd4: c = (k <= 4'd4) ? 8'h56 + 8'(k) : 8'h00;
                  default: c = '0;
                endcase
                if (lng && c >= 8'h41) c = c + 8'h20;
              end
            end
            2'd1: begin
              if (k == 4'd1) c = lng ? 8'h2D : 8'h2E;
              else if (k == 4'd2) c = 8'h2E;
              else if (k == 4'd9) c = 8'h82;
            end
            2'd2: begin
              if (k == 4'd1) c = 8'h80;
              else if (k == 4'd2) c = 8'h81;
            end
            default: c = '0;
          endcase
        end
      end
    endcase
    return c;
  endfunction

  // primed masks edges for one cycle after reset so keys held through reset are not seen as new presses
  always_comb begin
    rise      = key_down & ~key_q & {NUM_KEYS{primed}};
    any_rise  = |rise;
    first_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (rise[i] && first_idx == 4'd0) first_idx = 4'(i + 1);
    end
    key_held = |(key_down & (NUM_KEYS'(1) << (kidx - 4'd1)));
    long_now = cnt >= CNT_W'(LONG_PRESS_CYCLES);
    code     = map_code(mode_s, state_s, kidx, long_s);
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (any_rise) fsm_next = HELD;
      HELD:    if (!key_held) fsm_next = EMIT;
      EMIT:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_q & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : '0;
  assign out_long  = out_valid ? mem[rd_ptr][8] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      key_q     <= '0;
      primed    <= 1'b0;
      kidx      <= '0;
      mode_s    <= '0;
      state_s   <= '0;
      cnt       <= '0;
      long_s    <= 1'b0;
      push_q    <= 1'b0;
      push_code <= '0;
      push_long <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      fsm    <= fsm_next;
      key_q  <= key_down;
      primed <= 1'b1;
      push_q <= 1'b0;
      case (fsm)
        IDLE: if (any_rise) begin
          kidx    <= first_idx;
          mode_s  <= mode;
          state_s <= state;
          cnt     <= CNT_W'(1);
        end
        HELD: begin
          if (key_held) begin
            if (!long_now) cnt <= cnt + CNT_W'(1);
          end else begin
            long_s <= long_now;
          end
        end
        EMIT: begin
          push_q    <= code != 8'h00;
          push_code <= code;
          push_long <= long_s;
        end
        default: ;
      endcase
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
      if (push_q && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_long, push_code};
  end

endmodule

// File: tb/tb_key_event_mapper.sv
// Directed bench for key_event_mapper: table of single presses plus
// hand-written latency, snapshot, overflow and reset sequences.
module tb_key_event_mapper;
  localparam int NK = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [2:0]    state;
  logic [NK-1:0] key_down;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          out_long, overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_event_mapper #(
    .NUM_KEYS(NK),
    .LONG_PRESS_CYCLES(8),
    .FIFO_DEPTH(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .state(state),
    .key_down(key_down),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_long(out_long),
    .overflow(overflow)
  );

  typedef struct {
    logic [1:0] mode;
    logic [2:0] page;
    int         key;
    int         hold;
    int         beats;
    logic [7:0] data;
    logic       lng;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic press(input logic [1:0] m, input logic [2:0] pg, input int k, input int hold);
    @(negedge clk);
    mode = m;
    state = pg;
    key_down = '0;
    key_down[k-1] = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = '0;
  endtask

  task automatic collect(output int beats, output logic [7:0] d, output logic l);
    beats = 0;
    d = '0;
    l = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (beats == 0) begin
          d = out_data;
          l = out_long;
        end
        beats++;
      end
    end
  endtask

  initial begin
    int         b;
    logic [7:0] d;
    logic       l;
    logic [7:0] drain_exp [4];

    vt = '{
      '{2'd0, 3'd2, 3,  10, 1, 8'h69, 1'b1},
      '{2'd0, 3'd0, 5,  10, 1, 8'h35, 1'b1},
      '{2'd1, 3'd0, 1,  7,  1, 8'h2E, 1'b0},
      '{2'd1, 3'd0, 1,  8,  1, 8'h2D, 1'b1},
      '{2'd1, 3'd0, 4,  3,  0, 8'h00, 1'b0},
      '{2'd1, 3'd0, 9,  3,  1, 8'h82, 1'b0},
      '{2'd0, 3'd0, 11, 10, 1, 8'h1B, 1'b1},
      '{2'd0, 3'd0, 11, 2,  1, 8'h08, 1'b0},
      '{2'd0, 3'd1, 1,  2,  1, 8'h39, 1'b0},
      '{2'd0, 3'd1, 3,  10, 1, 8'h61, 1'b1},
      '{2'd0, 3'd4, 5,  2,  0, 8'h00, 1'b0},
      '{2'd0, 3'd4, 4,  2,  1, 8'h5A, 1'b0},
      '{2'd3, 3'd0, 1,  2,  0, 8'h00, 1'b0},
      '{2'd3, 3'd0, 12, 2,  1, 8'h0D, 1'b0},
      '{2'd0, 3'd5, 1,  2,  0, 8'h00, 1'b0},
      '{2'd0, 3'd0, 9,  10, 1, 8'h20, 1'b1},
      '{2'd0, 3'd0, 8,  2,  1, 8'h38, 1'b0},
      '{2'd2, 3'd0, 3,  2,  0, 8'h00, 1'b0},
      '{2'd0, 3'd0, 10, 2,  1, 8'h1B, 1'b0},
      '{2'd1, 3'd0, 2,  9,  1, 8'h2E, 1'b1},
      '{2'd0, 3'd3, 1,  1,  1, 8'h4F, 1'b0}
    };
    drain_exp = '{8'h80, 8'h80, 8'h80, 8'h81};

    rst = 1'b1;
    mode = '0;
    state = '0;
    key_down = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_long", 32'(out_long), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // release sampled at edge N; valid must appear only after N+2
    press(2'd0, 3'd2, 3, 3);
    @(posedge clk); #1;
    chk("lat_n_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_n1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h49);
    chk("lat_long", 32'(out_long), 0);
    @(posedge clk); #1;
    chk("lat_popped", 32'(out_valid), 0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      press(vt[i].mode, vt[i].page, vt[i].key, vt[i].hold);
      collect(b, d, l);
      chk($sformatf("vec%0d_beats", i), 32'(b), 32'(vt[i].beats));
      if (vt[i].beats > 0) begin
        chk($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].data));
        chk($sformatf("vec%0d_long", i), 32'(l), 32'(vt[i].lng));
      end
    end

    // keys 4 and 2 together in Setting mode, mode changed mid-hold
    @(negedge clk);
    mode = 2'd2;
    state = 3'd0;
    key_down = '0;
    key_down[3] = 1'b1;
    key_down[1] = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd0;
    repeat (2) @(negedge clk);
    key_down = '0;
    collect(b, d, l);
    chk("snap_beats", 32'(b), 1);
    chk("snap_data", 32'(d), 32'h81);
    chk("snap_long", 32'(l), 0);

    // fill FIFO with consumer stalled, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(2'd2, 3'd0, 1, 2);
      repeat (6) @(negedge clk);
      if (i == 3) begin
        chk("full_overflow", 32'(overflow), 0);
        chk("full_valid", 32'(out_valid), 1);
        chk("full_data", 32'(out_data), 32'h80);
      end
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head_stable", 32'(out_data), 32'h80);

    // push while full with a simultaneous pop must be accepted
    press(2'd2, 3'd0, 2, 2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("fullpop_valid", 32'(out_valid), 1);
    chk("fullpop_overflow", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(drain_exp[i]));
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_empty_data", 32'(out_data), 0);

    // reset during HELD with the key kept down through and after reset
    @(negedge clk);
    mode = 2'd2;
    state = 3'd0;
    key_down = '0;
    key_down[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_overflow", 32'(overflow), 0);
    collect(b, d, l);
    chk("rst2_held_beats", 32'(b), 0);
    @(negedge clk);
    key_down = '0;
    collect(b, d, l);
    chk("rst2_release_beats", 32'(b), 0);
    press(2'd2, 3'd0, 1, 2);
    collect(b, d, l);
    chk("rst2_repress_beats", 32'(b), 1);
    chk("rst2_repress_data", 32'(d), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
